// File: rtl/core_pkg.sv
// core_pkg: shared micro-op slot layout, field offsets and pack helper for the issue queue, ROB and execute units
package core_pkg;
    localparam int WIDTH_REG = 7;
    localparam int WIDTH_TAG = 3;
    localparam int WIDTH_BRM = 3;
    localparam int WIDTH_UOP = 7;
    localparam int WIDTH     = WIDTH_UOP + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3;
    localparam int OFS_P1    = 0;
    localparam int OFS_P2    = 1;
    localparam int OFS_VAL   = 2;
    localparam int OFS_PRS1  = 3;
    localparam int OFS_PRS2  = OFS_PRS1 + WIDTH_REG;
    localparam int OFS_PRD   = OFS_PRS2 + WIDTH_REG;
    localparam int OFS_TAG   = OFS_PRD + WIDTH_REG;
    localparam int OFS_BRM   = OFS_TAG + WIDTH_TAG;
    localparam int OFS_UOP   = OFS_BRM + WIDTH_BRM;

    typedef struct packed {
        logic [WIDTH_UOP-1:0] uop;
        logic [WIDTH_BRM-1:0] brmask;
        logic [WIDTH_TAG-1:0] tag;
        logic [WIDTH_REG-1:0] prd;
        logic [WIDTH_REG-1:0] prs2;
        logic [WIDTH_REG-1:0] prs1;
        logic                 val;
        logic                 p2;
        logic                 p1;
    } slot_t;

    function automatic slot_t slot_pack(
        input logic [WIDTH_UOP-1:0] uop,
        input logic [WIDTH_BRM-1:0] brmask,
        input logic [WIDTH_TAG-1:0] tag,
        input logic [WIDTH_REG-1:0] prd,
        input logic [WIDTH_REG-1:0] prs2,
        input logic [WIDTH_REG-1:0] prs1,
        input logic                 val,
        input logic                 p2,
        input logic                 p1
    );
        return {uop, brmask, tag, prd, prs2, prs1, val, p2, p1};
    endfunction
endpackage

// File: rtl/issq_select.sv
// issq_select: combinational IW-of-SIZE lowest-index priority picker with one-hot grants
module issq_select #(
    parameter int SIZE = 16,
    parameter int IW   = 2
) (
    input  logic [SIZE-1:0]         req,
    output logic [IW-1:0][SIZE-1:0] gnt
);
    always_comb begin
        logic [SIZE-1:0] rem;
        rem = req;
        for (int i = 0; i < IW; i++) begin
            gnt[i] = rem & -rem;
            rem    = rem & ~gnt[i];
        end
    end
endmodule

// File: rtl/issue_queue_nxm.sv
// issue_queue_nxm: DW-dispatch / IW-issue out-of-order issue queue with wakeup; ISSQ_BRKILL_EN adds branch-mask kill
module issue_queue_nxm
    import core_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int DW   = 4,
    parameter int IW   = 2,
    parameter int WB   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DW*WIDTH-1:0]        i_inst,
    input  logic                       i_en,
    output logic                       o_ready,
    input  logic [WB*WIDTH_REG-1:0]    i_wdest,
    input  logic                       i_issue_en,
    output logic [IW*WIDTH-1:0]        o_inst,
    output logic [IW-1:0]              o_valid,
    output logic [$clog2(SIZE+1)-1:0]  o_count
`ifdef ISSQ_BRKILL_EN
    ,
    input  logic [WIDTH_BRM:0]         i_kill
`endif
);
    localparam int CW = $clog2(SIZE + 1);

    slot_t [SIZE-1:0]         slot_q, slot_d;
    slot_t [IW-1:0]           out_q, out_d;
    logic  [IW-1:0]           oval_d;
    logic  [SIZE-1:0]         elig;
    logic  [IW-1:0][SIZE-1:0] gnt;
    logic  [CW-1:0]           count_d;
    logic                     kill_en;
    logic  [WIDTH_BRM-1:0]    kill_mask;

`ifdef ISSQ_BRKILL_EN
    assign kill_en   = i_kill[WIDTH_BRM];
    assign kill_mask = i_kill[WIDTH_BRM-1:0];
`else
    assign kill_en   = 1'b0;
    assign kill_mask = '0;
`endif

    function automatic logic woken(input logic [WIDTH_REG-1:0] r, input logic [WB*WIDTH_REG-1:0] wd);
        logic h;
        h = 1'b0;
        for (int w = 0; w < WB; w++)
            h = h | ((r != '0) && (r == wd[w*WIDTH_REG +: WIDTH_REG]));
        return h;
    endfunction

    function automatic logic killed(input logic [WIDTH_BRM-1:0] brm, input logic en, input logic [WIDTH_BRM-1:0] m);
        return en && ((brm & m) != '0);
    endfunction

    // eligibility uses registered ready bits, so a wakeup only counts from the next cycle
    always_comb begin
        for (int s = 0; s < SIZE; s++)
            elig[s] = slot_q[s].val & slot_q[s].p1 & slot_q[s].p2 & ~killed(slot_q[s].brmask, kill_en, kill_mask);
    end

    issq_select #(.SIZE(SIZE), .IW(IW)) u_select (
        .req (elig & {SIZE{i_issue_en}}),
        .gnt (gnt)
    );

    assign o_ready = (SIZE - int'(o_count)) >= DW;
    assign o_inst  = out_q;

    always_comb begin
        slot_t l;
        int    rank;
        int    frank;
        l       = '0;
        rank    = 0;
        frank   = 0;
        slot_d  = slot_q;
        out_d   = out_q;
        oval_d  = o_valid;
        count_d = '0;
        for (int s = 0; s < SIZE; s++) begin
            if (killed(slot_q[s].brmask, kill_en, kill_mask))
                slot_d[s].val = 1'b0;
            slot_d[s].p1 = slot_q[s].p1 | woken(slot_q[s].prs1, i_wdest);
            slot_d[s].p2 = slot_q[s].p2 | woken(slot_q[s].prs2, i_wdest);
        end
        if (i_issue_en) begin
            for (int i = 0; i < IW; i++) begin
                oval_d[i] = |gnt[i];
                for (int s = 0; s < SIZE; s++) begin
                    if (gnt[i][s]) begin
                        out_d[i]      = slot_q[s];
                        out_d[i].val  = 1'b1;
                        out_d[i].p1   = 1'b1;
                        out_d[i].p2   = 1'b1;
                        slot_d[s].val = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < IW; i++)
            if (killed(out_d[i].brmask, kill_en, kill_mask))
                oval_d[i] = 1'b0;
        // lane k lands in the rank-th slot that was free before this edge
        if (i_en && o_ready) begin
            for (int k = 0; k < DW; k++) begin
                l = slot_t'(i_inst[k*WIDTH +: WIDTH]);
                if (l.val && !killed(l.brmask, kill_en, kill_mask)) begin
                    l.p1  = l.p1 | (l.prs1 == '0) | woken(l.prs1, i_wdest);
                    l.p2  = l.p2 | (l.prs2 == '0) | woken(l.prs2, i_wdest);
                    frank = 0;
                    for (int s = 0; s < SIZE; s++) begin
                        if (!slot_q[s].val) begin
                            if (frank == rank)
                                slot_d[s] = l;
                            frank++;
                        end
                    end
                    rank++;
                end
            end
        end
        for (int s = 0; s < SIZE; s++)
            count_d = count_d + CW'(slot_d[s].val);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_q  <= '0;
            out_q   <= '0;
            o_valid <= '0;
            o_count <= '0;
        end else begin
            slot_q  <= slot_d;
            out_q   <= out_d;
            o_valid <= oval_d;
            o_count <= count_d;
        end
    end
endmodule

// File: tb/tb_issue_queue_nxm.sv
// tb_issue_queue_nxm: randomized scoreboard bench for issue_queue_nxm; kill stimulus only when ISSQ_BRKILL_EN is defined
module tb_issue_queue_nxm;
    import core_pkg::*;
    localparam int SIZE = 16;
    localparam int DW   = 4;
    localparam int IW   = 2;
    localparam int WB   = 4;
    localparam int CW   = $clog2(SIZE + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic                    issue_en = 1'b0;
    logic                    ready;
    logic [DW*WIDTH-1:0]     inst = '0;
    logic [WB*WIDTH_REG-1:0] wdest = '0;
    logic [IW*WIDTH-1:0]     o_inst;
    logic [IW-1:0]           o_valid;
    logic [CW-1:0]           count;
`ifdef ISSQ_BRKILL_EN
    logic [WIDTH_BRM:0]      kill = '0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_queue_nxm #(.SIZE(SIZE), .DW(DW), .IW(IW), .WB(WB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_inst     (inst),
        .i_en       (en),
        .o_ready    (ready),
        .i_wdest    (wdest),
        .i_issue_en (issue_en),
        .o_inst     (o_inst),
        .o_valid    (o_valid),
        .o_count    (count)
`ifdef ISSQ_BRKILL_EN
        ,
        .i_kill     (kill)
`endif
    );

    typedef struct {
        logic [IW-1:0]       val;
        logic [IW*WIDTH-1:0] inst;
        int                  cnt;
    } exp_t;
    exp_t sb[$];

    // reference model: one entry per slot position
    bit                  mv[SIZE];
    bit                  m1[SIZE];
    bit                  m2[SIZE];
    slot_t               mp[SIZE];
    logic [IW-1:0]       mval;
    logic [IW*WIDTH-1:0] minst;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [WIDTH_REG-1:0] r);
        for (int w = 0; w < WB; w++)
            if (wdest[w*WIDTH_REG +: WIDTH_REG] != '0 && wdest[w*WIDTH_REG +: WIDTH_REG] == r)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit mkill(input slot_t p);
`ifdef ISSQ_BRKILL_EN
        return kill[WIDTH_BRM] && ((p.brmask & kill[WIDTH_BRM-1:0]) != '0);
`else
        return (p.brmask & '0) != '0;
`endif
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int s = 0; s < SIZE; s++)
            c += int'(mv[s]);
        return c;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SIZE; s++) begin
            mv[s] = 1'b0;
            m1[s] = 1'b0;
            m2[s] = 1'b0;
            mp[s] = '0;
        end
        mval  = '0;
        minst = '0;
    endtask

    // applies the current inputs to the model as of the coming edge and queues the expected outputs
    task automatic model_step();
        bit    freeb[SIZE];
        bit    rdy;
        int    n;
        slot_t p;
        exp_t  e;
        n   = 0;
        rdy = (SIZE - mcount()) >= DW;
        for (int s = 0; s < SIZE; s++)
            freeb[s] = !mv[s];
        if (issue_en) begin
            mval = '0;
            for (int s = 0; s < SIZE && n < IW; s++) begin
                if (mv[s] && m1[s] && m2[s] && !mkill(mp[s])) begin
                    p = mp[s];
                    p.val = 1'b1;
                    p.p1 = 1'b1;
                    p.p2 = 1'b1;
                    minst[n*WIDTH +: WIDTH] = p;
                    mval[n] = 1'b1;
                    mv[s] = 1'b0;
                    n++;
                end
            end
        end
        for (int s = 0; s < SIZE; s++) begin
            if (mv[s] && mkill(mp[s]))
                mv[s] = 1'b0;
            if (mv[s]) begin
                m1[s] = m1[s] | hit(mp[s].prs1);
                m2[s] = m2[s] | hit(mp[s].prs2);
            end
        end
        for (int i = 0; i < IW; i++)
            if (mval[i] && mkill(slot_t'(minst[i*WIDTH +: WIDTH])))
                mval[i] = 1'b0;
        if (en && rdy) begin
            for (int k = 0; k < DW; k++) begin
                p = slot_t'(inst[k*WIDTH +: WIDTH]);
                if (p.val && !mkill(p)) begin
                    for (int s = 0; s < SIZE; s++) begin
                        if (freeb[s]) begin
                            freeb[s] = 1'b0;
                            mv[s] = 1'b1;
                            mp[s] = p;
                            m1[s] = p.p1 || p.prs1 == '0 || hit(p.prs1);
                            m2[s] = p.p2 || p.prs2 == '0 || hit(p.prs2);
                            break;
                        end
                    end
                end
            end
        end
        e.val  = mval;
        e.inst = minst;
        e.cnt  = mcount();
        sb.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    function automatic slot_t mk(input int prs1, input int prs2, input int brm);
        return slot_pack(7'($urandom), WIDTH_BRM'(brm), WIDTH_TAG'($urandom), WIDTH_REG'($urandom_range(1, 100)),
                         WIDTH_REG'(prs2), WIDTH_REG'(prs1), 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic rand_inputs(input int pen, input int piss, input int pwake);
        slot_t p;
        en = $urandom_range(0, 99) < pen;
        for (int k = 0; k < DW; k++) begin
            p = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            p.val = $urandom_range(0, 3) != 0;
            p.p1  = $urandom_range(0, 7) == 0;
            p.p2  = $urandom_range(0, 7) == 0;
            inst[k*WIDTH +: WIDTH] = p;
        end
        for (int w = 0; w < WB; w++)
            wdest[w*WIDTH_REG +: WIDTH_REG] = ($urandom_range(0, 99) < pwake) ? WIDTH_REG'($urandom_range(1, 7)) : '0;
        issue_en = $urandom_range(0, 99) < piss;
`ifdef ISSQ_BRKILL_EN
        kill = {$urandom_range(0, 99) < 4, WIDTH_BRM'($urandom)};
`endif
    endtask

    task automatic quiet();
        en = 1'b0;
        inst = '0;
        wdest = '0;
`ifdef ISSQ_BRKILL_EN
        kill = '0;
`endif
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("o_valid", o_valid, e.val);
            check("o_count", count, e.cnt);
            check("o_ready", ready, (SIZE - e.cnt) >= DW);
            for (int i = 0; i < IW; i++)
                if (e.val[i])
                    check("o_inst", o_inst[i*WIDTH +: WIDTH], e.inst[i*WIDTH +: WIDTH]);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset o_valid", o_valid, 0);
        check("reset o_count", count, 0);
        check("reset o_ready", ready, 1);
        check("reset o_inst", o_inst, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // four ready ops drain two per edge
        quiet();
        issue_en = 1'b1;
        en = 1'b1;
        for (int k = 0; k < DW; k++)
            inst[k*WIDTH +: WIDTH] = mk(0, 0, 1);
        tick();
        quiet();
        repeat (3) tick();

        // single op waits for a writeback on lane 2
        en = 1'b1;
        inst[WIDTH-1:0] = mk(9, 0, 1);
        tick();
        quiet();
        repeat (2) tick();
        wdest[2*WIDTH_REG +: WIDTH_REG] = 7'd9;
        tick();
        quiet();
        repeat (3) tick();

        // fill to 13, dispatch must be refused, hold issue, then drain
        issue_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            en = 1'b1;
            for (int k = 0; k < DW; k++)
                inst[k*WIDTH +: WIDTH] = (b < 3 || k == 0) ? mk(5, 0, 1) : '0;
            tick();
        end
        for (int k = 0; k < DW; k++)
            inst[k*WIDTH +: WIDTH] = mk(0, 0, 1);
        repeat (3) tick();
        quiet();
        wdest[WIDTH_REG-1:0] = 7'd5;
        tick();
        quiet();
        repeat (5) tick();
        issue_en = 1'b1;
        repeat (10) tick();

`ifdef ISSQ_BRKILL_EN
        // six held ops, two on the killed branch
        issue_en = 1'b0;
        en = 1'b1;
        inst[0*WIDTH +: WIDTH] = mk(3, 0, 1);
        inst[1*WIDTH +: WIDTH] = mk(3, 0, 2);
        inst[2*WIDTH +: WIDTH] = mk(3, 0, 4);
        inst[3*WIDTH +: WIDTH] = mk(3, 0, 5);
        tick();
        quiet();
        en = 1'b1;
        inst[0*WIDTH +: WIDTH] = mk(3, 0, 2);
        inst[1*WIDTH +: WIDTH] = mk(3, 0, 1);
        tick();
        quiet();
        kill = {1'b1, 3'b010};
        tick();
        quiet();
        wdest[WIDTH_REG-1:0] = 7'd3;
        tick();
        quiet();
        issue_en = 1'b1;
        repeat (5) tick();
`endif

        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 600; c++) begin
                case (ph)
                    0: rand_inputs(60, 80, 40);
                    1: rand_inputs(90, 30, 20);
                    default: rand_inputs(30, 95, 60);
                endcase
                tick();
            end
        end

        // eight held entries, then asynchronous reset between edges
        quiet();
        issue_en = 1'b1;
        repeat (12) tick();
        issue_en = 1'b0;
        for (int b = 0; b < 2; b++) begin
            en = 1'b1;
            for (int k = 0; k < DW; k++)
                inst[k*WIDTH +: WIDTH] = mk(6, 0, 1);
            tick();
        end
        quiet();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst o_valid", o_valid, 0);
        check("async rst o_count", count, 0);
        check("async rst o_ready", ready, 1);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rand_inputs(60, 80, 40);
            tick();
        end
        quiet();
        issue_en = 1'b1;
        repeat (12) tick();
        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
